// File: rtl/seg7_pkg.sv
// Shared definitions for the scrolling seven-segment marquee.
// Blank pattern, active-low hex glyph table and controller states.
package seg7_pkg;

    localparam logic [7:0] BLANK = 8'hFF;

    localparam logic [7:0] HEX_TAB [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0,
        8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83,
        8'hC6, 8'hA1, 8'h86, 8'h8E
    };

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SCROLL
    } state_t;

    function automatic logic [7:0] hex_seg(input logic [3:0] nib);
        return HEX_TAB[nib];
    endfunction

endpackage

// File: rtl/seg7_hex_enc.sv
// Combinational nibble to active-low seven-segment glyph encoder.
module seg7_hex_enc
    import seg7_pkg::*;
(
    input  logic [3:0] nib,
    output logic [7:0] seg
);

    assign seg = hex_seg(nib);

endmodule

// File: rtl/seg7_marquee.sv
// Message buffer that scrolls right-to-left across an 8-digit display.
// Optional SEG7_MARQUEE_HEX_EN adds hex_sel to store nibbles as glyphs.
module seg7_marquee
    import seg7_pkg::*;
#(
    parameter int DEPTH    = 16,
    parameter int TICK_DIV = 25_000_000
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     clr,
    input  logic                     wr_valid,
    input  logic [7:0]               wr_data,
    output logic                     wr_ready,
    input  logic                     start,
    input  logic                     en,
`ifdef SEG7_MARQUEE_HEX_EN
    input  logic                     hex_sel,
`endif
    output logic [63:0]              o_data,
    output logic                     o_disp_mode,
    output logic [$clog2(DEPTH):0]   o_len,
    output logic                     o_wrap
);

    localparam int LW = $clog2(DEPTH) + 1;
    localparam int AW = $clog2(DEPTH);
    localparam int PW = $clog2(DEPTH + 8) + 1;
    localparam int CW = $clog2(TICK_DIV);

    state_t          state;
    logic [LW-1:0]   len;
    logic [PW-1:0]   p;
    logic [CW-1:0]   cnt;
    logic [7:0]      mem [DEPTH];
    logic [7:0]      wdata;
    logic [PW-1:0]   period;
    logic [63:0]     frame;
    logic [PW-1:0]   idx;
    logic [7:0]      digit;
    logic            accept;
    logic            tick;

`ifdef SEG7_MARQUEE_HEX_EN
    logic [7:0] hex_byte;

    seg7_hex_enc u_hex (
        .nib (wr_data[3:0]),
        .seg (hex_byte)
    );

    assign wdata = hex_sel ? hex_byte : wr_data;
`else
    assign wdata = wr_data;
`endif

    assign wr_ready = rstn && !clr
                   && (state != ST_SCROLL)
                   && (len < LW'(DEPTH));
    assign accept      = wr_valid && wr_ready;
    assign o_disp_mode = 1'b1;
    assign o_len       = len;
    assign period      = PW'(len) + PW'(8);
    assign tick        = en && (cnt == CW'(TICK_DIV - 1));

    // Eight leading blanks precede the message in the virtual ring.
    always_comb begin
        frame = '1;
        idx   = '0;
        digit = BLANK;
        for (int i = 0; i < 8; i++) begin
            idx = p + PW'(i);
            if (idx >= period)
                idx = idx - period;
            if (idx >= PW'(8))
                digit = mem[AW'(idx - PW'(8))];
            else
                digit = BLANK;
            frame[8*(7-i) +: 8] = digit;
        end
    end

    always_ff @(posedge clk) begin
        if (accept)
            mem[len[AW-1:0]] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (!rstn || clr) begin
            state  <= ST_IDLE;
            len    <= '0;
            p      <= '0;
            cnt    <= '0;
            o_data <= '1;
            o_wrap <= 1'b0;
        end else begin
            o_wrap <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (accept) begin
                        len   <= len + LW'(1);
                        state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (accept)
                        len <= len + LW'(1);
                    if (start) begin
                        state <= ST_SCROLL;
                        p     <= '0;
                        cnt   <= '0;
                    end
                end
                ST_SCROLL: begin
                    if (tick) begin
                        cnt <= '0;
                        if (p == period - PW'(1)) begin
                            p      <= '0;
                            o_wrap <= 1'b1;
                        end else begin
                            p <= p + PW'(1);
                        end
                    end else if (en) begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
            o_data <= (state == ST_SCROLL) ? frame : '1;
        end
    end

endmodule

// File: tb/tb_seg7_marquee.sv
// Directed bench for seg7_marquee with DEPTH=16, TICK_DIV=4.
module tb_seg7_marquee;

    logic        clk = 1'b0;
    logic        rstn;
    logic        clr;
    logic        wr_valid;
    logic [7:0]  wr_data;
    logic        wr_ready;
    logic        start;
    logic        en;
    logic [63:0] o_data;
    logic        o_disp_mode;
    logic [4:0]  o_len;
    logic        o_wrap;
`ifdef SEG7_MARQUEE_HEX_EN
    logic        hex_sel;
`endif

    int ncomp = 0;
    int nfail = 0;
    int nwrap = 0;

    always #5 clk = ~clk;

    seg7_marquee #(
        .DEPTH    (16),
        .TICK_DIV (4)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .clr         (clr),
        .wr_valid    (wr_valid),
        .wr_data     (wr_data),
        .wr_ready    (wr_ready),
        .start       (start),
        .en          (en),
`ifdef SEG7_MARQUEE_HEX_EN
        .hex_sel     (hex_sel),
`endif
        .o_data      (o_data),
        .o_disp_mode (o_disp_mode),
        .o_len       (o_len),
        .o_wrap      (o_wrap)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        ncomp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rstn     = 1'b0;
        clr      = 1'b0;
        wr_valid = 1'b0;
        wr_data  = 8'h00;
        start    = 1'b0;
        en       = 1'b0;
`ifdef SEG7_MARQUEE_HEX_EN
        hex_sel  = 1'b0;
`endif
        step();
        step();
        chk("rst_data", o_data, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("rst_len", 64'(o_len), 64'd0);
        chk("rst_wrap", 64'(o_wrap), 64'd0);
        chk("rst_ready", 64'(wr_ready), 64'd0);
        chk("rst_mode", 64'(o_disp_mode), 64'd1);

        rstn = 1'b1;
        #1;
        chk("rel_ready", 64'(wr_ready), 64'd1);

        // three-byte message
        wr_valid = 1'b1;
        wr_data  = 8'hC0;
        step();
        wr_data  = 8'hF9;
        step();
        wr_data  = 8'hA4;
        step();
        wr_valid = 1'b0;
        chk("load_len", 64'(o_len), 64'd3);
        chk("load_data", o_data, 64'hFFFF_FFFF_FFFF_FFFF);

        start = 1'b1;
        en    = 1'b1;
        step();
        start = 1'b0;
        chk("scr_len", 64'(o_len), 64'd3);
        chk("scr0", o_data, 64'hFFFF_FFFF_FFFF_FFFF);

        for (int c = 1; c <= 98; c++) begin
            step();
            if (o_wrap)
                nwrap++;
            if (c == 4)
                chk("scr_c4", o_data, 64'hFFFF_FFFF_FFFF_FFFF);
            if (c == 5)
                chk("scr_c5", o_data, 64'hFFFF_FFFF_FFFF_FFC0);
            if (c == 9)
                chk("scr_c9", o_data, 64'hFFFF_FFFF_FFFF_C0F9);
            if (c == 13)
                chk("scr_c13", o_data, 64'hFFFF_FFFF_FFC0_F9A4);
            if (c == 33)
                chk("scr_c33", o_data, 64'hC0F9_A4FF_FFFF_FFFF);
            if (c == 41)
                chk("scr_c41", o_data, 64'hA4FF_FFFF_FFFF_FFFF);
            if (c == 43)
                chk("wrap_c43", 64'(o_wrap), 64'd0);
            if (c == 44)
                chk("wrap_c44", 64'(o_wrap), 64'd1);
            if (c == 45) begin
                chk("wrap_c45", 64'(o_wrap), 64'd0);
                chk("wrap_data", o_data, 64'hFFFF_FFFF_FFFF_FFFF);
            end
            if (c == 88)
                chk("wrap_c88", 64'(o_wrap), 64'd1);
        end
        chk("wrap_count", 64'(nwrap), 64'd2);

        // pause with counter at phase 2
        en = 1'b0;
        for (int k = 0; k < 10; k++)
            step();
        chk("pause_data", o_data, 64'hFFFF_FFFF_FFFF_C0F9);
        en = 1'b1;
        step();
        step();
        chk("resume_hold", o_data, 64'hFFFF_FFFF_FFFF_C0F9);
        step();
        chk("resume_adv", o_data, 64'hFFFF_FFFF_FFC0_F9A4);

        clr      = 1'b1;
        wr_valid = 1'b1;
        wr_data  = 8'h55;
        start    = 1'b1;
        #1;
        chk("clr_ready", 64'(wr_ready), 64'd0);
        step();
        chk("clr_len", 64'(o_len), 64'd0);
        chk("clr_data", o_data, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("clr_wrap", 64'(o_wrap), 64'd0);
        clr      = 1'b0;
        wr_valid = 1'b0;
        start    = 1'b0;
        #1;
        chk("clr_rel", 64'(wr_ready), 64'd1);
        step();
        chk("clr_len2", 64'(o_len), 64'd0);

        // overfill by one byte
        for (int i = 0; i < 17; i++) begin
            wr_valid = 1'b1;
            wr_data  = 8'(8'h10 + i);
            #1;
            chk($sformatf("fill_ready%0d", i), 64'(wr_ready),
                (i < 16) ? 64'd1 : 64'd0);
            step();
        end
        wr_valid = 1'b0;
        chk("fill_len", 64'(o_len), 64'd16);
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (5) step();
        chk("fill_frame", o_data, 64'hFFFF_FFFF_FFFF_FF10);

        rstn = 1'b0;
        step();
        chk("mid_wrap", 64'(o_wrap), 64'd0);
        chk("mid_len", 64'(o_len), 64'd0);
        chk("mid_data", o_data, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("mid_ready", 64'(wr_ready), 64'd0);
        rstn = 1'b1;
        step();

`ifdef SEG7_MARQUEE_HEX_EN
        hex_sel  = 1'b1;
        wr_valid = 1'b1;
        wr_data  = 8'h0A;
        step();
        wr_valid = 1'b0;
        hex_sel  = 1'b0;
        start    = 1'b1;
        step();
        start    = 1'b0;
        repeat (5) step();
        chk("hex_frame", o_data, 64'hFFFF_FFFF_FFFF_FF88);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 ncomp, nfail);
        $finish;
    end

endmodule

// File: doc/seg7_marquee.md
SEG7_MARQUEE -- requirements
Module: seg7_marquee

Interface
REQ-001 Parameter DEPTH, default 16, SHALL set the message buffer size in bytes (power of two, 8..64).
REQ-002 Parameter TICK_DIV, default 25_000_000, SHALL set the clk cycles per scroll step (>=2).
REQ-003 clk  input  1  single system clock; all logic SHALL be on its rising edge.
REQ-004 rstn  input  1  reset SHALL be synchronous and active-low.
REQ-005 clr  input  1  synchronous buffer clear.
REQ-006 wr_valid  input  1  write byte offered.
REQ-007 wr_data  input  8  segment pattern (active-low, dp = bit 7).
REQ-008 wr_ready  output  1  write byte accepted when high together with wr_valid.
REQ-009 start  input  1  begin scrolling (pulse).
REQ-010 en  input  1  scroll enable; low pauses.
REQ-011 o_data  output  64  display frame for the downstream seg7x16 i_data; digit k is bits [8k+7:8k]; digit 7 is leftmost.
REQ-012 o_disp_mode  output  1  SHALL be constant 1 (raw pattern mode downstream).
REQ-013 o_len  output  $clog2(DEPTH)+1  number of stored bytes.
REQ-014 o_wrap  output  1  one-cycle pulse on scroll wrap.

Function
REQ-015 The block SHALL have states IDLE (len=0), LOAD (0<len, not scrolling) and SCROLL.
REQ-016 wr_ready SHALL be high only in IDLE/LOAD with len<DEPTH and clr low.
REQ-017 An accepted write SHALL store wr_data at index len, increment len, and move IDLE->LOAD.
REQ-018 start in LOAD SHALL enter SCROLL next cycle with position p=0 and the tick counter at 0; start in IDLE or SCROLL SHALL be ignored.
REQ-019 A write and start in the same LOAD cycle SHALL both take effect; the written byte SHALL be part of the message.
REQ-020 The virtual sequence SHALL be V = 8 blank bytes (8'hFF) followed by msg[0..len-1], with period P = len+8.
REQ-021 In SCROLL, digit (7-i) SHALL show V[(p+i) mod P] for i=0..7, so text enters at the right and exits at the left.
REQ-022 In IDLE and LOAD, o_data SHALL be all 8'hFF.
REQ-023 The tick counter SHALL count only while en=1 in SCROLL.
REQ-024 When the tick counter reaches TICK_DIV-1, it SHALL return to 0 and p SHALL advance by 1.
REQ-025 When p advances from P-1 it SHALL wrap to 0, and o_wrap SHALL pulse in that same cycle.
REQ-026 en=0 SHALL freeze the tick counter, p and o_data.
REQ-027 o_data SHALL be registered, changing one cycle after the p update (latency 1).
REQ-028 clr SHALL override all inputs: next cycle state=IDLE, len=0, p=0, counter=0, o_data=all 8'hFF.

Reset
REQ-029 While rstn=0 at a clk edge, the block SHALL enter IDLE and the outputs SHALL be:
- o_data = 64'hFFFF_FFFF_FFFF_FFFF
- o_len = 0
- o_wrap = 0
- wr_ready = 0 during reset, 1 after release
- o_disp_mode = 1
REQ-030 Reset asserted mid-SCROLL SHALL discard buffer contents and position without producing an o_wrap pulse.

Configuration
REQ-031 Macro SEG7_MARQUEE_HEX_EN defined SHALL add input hex_sel (1 bit).
REQ-032 With SEG7_MARQUEE_HEX_EN defined and hex_sel=1, an accepted byte SHALL be stored as the active-low encoding of wr_data[3:0]:
- 0-7: C0, F9, A4, B0, 99, 92, 82, F8
- 8-F: 80, 90, 88, 83, C6, A1, 86, 8E
REQ-033 Without SEG7_MARQUEE_HEX_EN, the hex_sel port SHALL be absent and bytes SHALL be stored raw.

Structure
REQ-034 Shared package seg7_pkg SHALL hold the blank constant 8'hFF, the 16-entry hex segment table and the state enum.
REQ-035 Sub-module seg7_hex_enc (combinational 4-bit to 8-bit encoder using seg7_pkg) SHALL be instantiated only under SEG7_MARQUEE_HEX_EN.

Verification (TICK_DIV=4, DEPTH=16)
REQ-036 Reset, then write C0,F9,A4 and pulse start -> o_len=3; o_data=FF..FF; after 4 en cycles (+1 latency) o_data=FFFF_FFFF_FFFF_FFC0.
REQ-037 Continue the REQ-036 run -> o_wrap pulses once every 11 steps (44 cycles), and o_data returns to all FF at wrap.
REQ-038 Write 17 bytes -> wr_ready drops after the 16th byte; the 17th is not stored; o_len=16.
REQ-039 Drop en for 10 cycles during SCROLL -> o_data and p are unchanged; scrolling resumes with the same tick phase.
REQ-040 Assert clr during SCROLL with wr_valid=1 and start=1 -> next cycle IDLE, o_len=0, o_data all FF, no write stored.
REQ-041 With SEG7_MARQUEE_HEX_EN and hex_sel=1, write 4'hA -> stored byte is 88.
